// File: rtl/frame_write_ctrl.sv
// Write-side frame sequencer for the HS FIFO: writes framed bytes, records stop address and length.
// Optional FRAME_TIMEOUT_EN adds TO_CYC / to_err to abandon a stalled frame.
module frame_write_ctrl #(
    parameter int DW        = 8,
    parameter int AW        = 9,
    parameter int TRAIL_LEN = 24,
    parameter int MAX_LEN   = 400,
    parameter int LW        = 10
`ifdef FRAME_TIMEOUT_EN
    , parameter int TO_CYC  = 1024
`endif
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    input  logic          in_sof,
    input  logic          trail_detected,
    input  logic          wfull,
    input  logic [AW-1:0] waddr,
    output logic          in_ready,
    output logic [DW-1:0] wdata,
    output logic          winc,
    output logic          frame_done,
    output logic [AW-1:0] stop_addr,
    output logic [LW-1:0] frame_len,
    output logic          ovf_err,
`ifdef FRAME_TIMEOUT_EN
    output logic          to_err,
`endif
    output logic          busy
);

    typedef enum logic [1:0] {IDLE, WRITE, DONE, DROP} state_t;

    localparam logic [LW-1:0] MAX_L = LW'(MAX_LEN);
    localparam logic [AW-1:0] TRAIL = AW'(TRAIL_LEN);

    state_t        state;
    logic [LW-1:0] cnt;
    logic [LW-1:0] cnt_inc;
    logic          accept;

`ifdef FRAME_TIMEOUT_EN
    localparam int TW = $clog2(TO_CYC + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TO_CYC - 1);
    logic [TW-1:0] to_cnt;
`endif

    // Handshake: a word moves only when in_valid and in_ready are both high in the same cycle;
    // the upstream holds in_data/in_sof/trail_detected stable until then.
    always_comb begin
        in_ready = 1'b0;
        if (!rst) begin
            case (state)
                IDLE, WRITE: in_ready = !wfull;
                DROP:        in_ready = 1'b1;
                default:     in_ready = 1'b0;
            endcase
        end
    end

    assign accept  = in_valid & in_ready;
    assign winc    = accept & ((state == WRITE) | ((state == IDLE) & in_sof));
    assign wdata   = winc ? in_data : '0;
    assign busy    = (state != IDLE);
    assign cnt_inc = cnt + LW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            frame_done <= 1'b0;
            stop_addr  <= '0;
            frame_len  <= '0;
            ovf_err    <= 1'b0;
`ifdef FRAME_TIMEOUT_EN
            to_cnt     <= '0;
            to_err     <= 1'b0;
`endif
        end else begin
            frame_done <= 1'b0;
`ifdef FRAME_TIMEOUT_EN
            to_err     <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (accept && in_sof) begin
                        cnt     <= LW'(1);
                        ovf_err <= 1'b0;
`ifdef FRAME_TIMEOUT_EN
                        to_cnt  <= '0;
`endif
                        if (trail_detected) begin
                            stop_addr  <= waddr - TRAIL;
                            frame_len  <= LW'(1);
                            frame_done <= 1'b1;
                            state      <= DONE;
                        end else begin
                            state <= WRITE;
                        end
                    end
                end
                WRITE: begin
                    if (accept) begin
`ifdef FRAME_TIMEOUT_EN
                        to_cnt <= '0;
`endif
                        if (cnt != MAX_L) cnt <= cnt_inc;
                        if (trail_detected) begin
                            stop_addr  <= waddr - TRAIL;
                            frame_len  <= cnt_inc;
                            frame_done <= 1'b1;
                            state      <= DONE;
                        end else if (cnt_inc == MAX_L) begin
                            ovf_err <= 1'b1;
                            state   <= DROP;
                        end
                    end
`ifdef FRAME_TIMEOUT_EN
                    else if (to_cnt == TO_LAST) begin
                        to_cnt <= '0;
                        to_err <= 1'b1;
                        state  <= DROP;
                    end else begin
                        to_cnt <= to_cnt + TW'(1);
                    end
`endif
                end
                DONE: state <= IDLE;
                // Discard everything, including stray SOFs, until the frame's trailer goes by.
                DROP: if (accept && trail_detected) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_frame_write_ctrl.sv
// Directed bench for frame_write_ctrl: FIFO-pointer model, write scoreboard, end-of-run report.
module tb_frame_write_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid, in_sof, trail_detected, wfull;
    logic [8:0] waddr;
    logic       in_ready, winc, frame_done, ovf_err, busy;
    logic [7:0] wdata;
    logic [8:0] stop_addr;
    logic [9:0] frame_len;
`ifdef FRAME_TIMEOUT_EN
    logic       to_err;
`endif

    int checks   = 0;
    int failures = 0;
    int wr_cnt   = 0;
    logic [7:0] exp_q[$];

    frame_write_ctrl #(
        .DW(8), .AW(9), .TRAIL_LEN(24), .MAX_LEN(400), .LW(10)
`ifdef FRAME_TIMEOUT_EN
        , .TO_CYC(16)
`endif
    ) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_sof(in_sof),
        .trail_detected(trail_detected), .wfull(wfull), .waddr(waddr),
        .in_ready(in_ready), .wdata(wdata), .winc(winc), .frame_done(frame_done),
        .stop_addr(stop_addr), .frame_len(frame_len), .ovf_err(ovf_err),
`ifdef FRAME_TIMEOUT_EN
        .to_err(to_err),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Scoreboard: every FIFO write must match the next expected word.
    always @(negedge clk) begin
        if (winc) begin
            wr_cnt++;
            if (exp_q.size() == 0) check("unexpected_write", 32'(wdata), 32'hFFFF);
            else check("wdata", 32'(wdata), 32'(exp_q.pop_front()));
        end
    end

    // Present one word, wait (bounded) for acceptance, then advance the FIFO pointer model.
    task automatic send(input logic [7:0] d, input logic sof, input logic tr, input logic wr);
        int n;
        logic w;
        n = 0;
        in_data = d; in_sof = sof; trail_detected = tr; in_valid = 1'b1;
        if (wr) exp_q.push_back(d);
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("ready_timeout", 32'(in_ready), 32'd1);
        w = winc;
        check("winc", 32'(w), 32'(wr));
        @(posedge clk); #1;
        if (w) waddr = waddr + 9'd1;
        in_valid = 1'b0; in_sof = 1'b0; trail_detected = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] base, input int len);
        for (int i = 0; i < len; i++)
            send(base + 8'(i), (i == 0), (i == len - 1), 1'b1);
    endtask

    task automatic check_done(input string tag, input logic [8:0] sa, input logic [9:0] fl);
        @(negedge clk);
        check({tag, "_done"}, 32'(frame_done), 32'd1);
        check({tag, "_ready"}, 32'(in_ready), 32'd0);
        check({tag, "_stop"}, 32'(stop_addr), 32'(sa));
        check({tag, "_len"}, 32'(frame_len), 32'(fl));
        @(posedge clk); #1;
        @(negedge clk);
        check({tag, "_done_pulse"}, 32'(frame_done), 32'd0);
        check({tag, "_idle"}, 32'(busy), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        int wr0;
        logic [7:0] d;
        logic [8:0] exp_sa;

        rst = 1'b1; in_data = '0; in_valid = 1'b0; in_sof = 1'b0;
        trail_detected = 1'b0; wfull = 1'b0; waddr = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_stop_addr", 32'(stop_addr), 32'd0);
        check("rst_frame_len", 32'(frame_len), 32'd0);
        check("rst_ovf_err", 32'(ovf_err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;

        // Non-SOF word in IDLE is accepted and discarded.
        send(8'h77, 1'b0, 1'b0, 1'b0);

        // 30-word frame, trailer sampled with waddr=40 -> stop 16.
        waddr = 9'd11;
        wr0 = wr_cnt;
        send_frame(8'h10, 30);
        check("t1_writes", 32'(wr_cnt - wr0), 32'd30);
        check_done("t1", 9'd16, 10'd30);

        // 20-word frame with a 5-cycle full stall after word 10.
        waddr = 9'd100;
        for (int i = 0; i < 10; i++) send(8'h40 + 8'(i), (i == 0), 1'b0, 1'b1);
        in_data = 8'h4A; in_valid = 1'b1; wfull = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_ready", 32'(in_ready), 32'd0);
            check("stall_winc", 32'(winc), 32'd0);
            @(posedge clk); #1;
        end
        wfull = 1'b0;
        for (int i = 10; i < 20; i++) send(8'h40 + 8'(i), 1'b0, (i == 19), 1'b1);
        check_done("t2", 9'd95, 10'd20);

        // Trailer at waddr=10 wraps to 498.
        waddr = 9'd8;
        send_frame(8'h60, 3);
        check_done("t3", 9'd498, 10'd3);

        // One-word frame.
        waddr = 9'd30;
        send(8'h55, 1'b1, 1'b1, 1'b1);
        check_done("t1w", 9'd6, 10'd1);

        // 400 words without trailer -> overflow, rest dropped.
        waddr = 9'd0;
        for (int i = 0; i < 400; i++) begin
            d = 8'(i);
            send(d, (i == 0), 1'b0, 1'b1);
        end
        @(negedge clk);
        check("ovf_set", 32'(ovf_err), 32'd1);
        check("ovf_busy", 32'(busy), 32'd1);
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) send(8'hC0 + 8'(i), (i == 1), 1'b0, 1'b0);
        send(8'hCF, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        check("ovf_no_done", 32'(frame_done), 32'd0);
        check("ovf_idle", 32'(busy), 32'd0);
        check("ovf_stop_kept", 32'(stop_addr), 32'd6);
        check("ovf_len_kept", 32'(frame_len), 32'd1);
        check("ovf_sticky", 32'(ovf_err), 32'd1);
        @(posedge clk); #1;
        waddr = 9'd50;
        send(8'hA0, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        check("ovf_cleared", 32'(ovf_err), 32'd0);
        @(posedge clk); #1;
        send(8'hA1, 1'b0, 1'b1, 1'b1);
        check_done("t4", 9'd27, 10'd2);

        // Reset mid-frame at cnt=7; the word presented during reset is not written.
        for (int i = 0; i < 7; i++) send(8'hB0 + 8'(i), (i == 0), 1'b0, 1'b1);
        in_data = 8'hEE; in_valid = 1'b1; rst = 1'b1;
        @(negedge clk);
        check("rst_cycle_winc", 32'(winc), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("rst2_busy", 32'(busy), 32'd0);
        check("rst2_stop_addr", 32'(stop_addr), 32'd0);
        check("rst2_frame_len", 32'(frame_len), 32'd0);
        check("rst2_frame_done", 32'(frame_done), 32'd0);
        @(posedge clk); #1;
        exp_sa = waddr + 9'd2 - 9'd24;
        send_frame(8'hD0, 3);
        check_done("t5", exp_sa, 10'd3);

`ifdef FRAME_TIMEOUT_EN
        // Stall 16 cycles in WRITE -> to_err pulse, frame abandoned.
        begin
            int seen;
            seen = 0;
            send(8'hE0, 1'b1, 1'b0, 1'b1);
            for (int i = 1; i <= 40 && seen == 0; i++) begin
                @(negedge clk);
                if (to_err) seen = i;
                @(posedge clk); #1;
            end
            check("to_err_cycle", 32'(seen), 32'd17);
            @(negedge clk);
            check("to_err_pulse", 32'(to_err), 32'd0);
            check("to_drop_busy", 32'(busy), 32'd1);
            check("to_no_done", 32'(frame_done), 32'd0);
            @(posedge clk); #1;
            send(8'hE1, 1'b0, 1'b1, 1'b0);
            @(negedge clk);
            check("to_idle", 32'(busy), 32'd0);
            check("to_stop_kept", 32'(stop_addr), 32'(exp_sa));
            @(posedge clk); #1;
        end
`endif

        check("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
